aes_enc_round_ctrl: RTL and testbench

- Iterative AES encryption controller. Holds a 128-bit state register and applies one full cipher round per clock.
- Each round uses SubBytes, ShiftRows, the existing MixColumns block and AddRoundKey.
- Sequences the initial AddRoundKey, NR-1 full rounds, and a final round that skips MixColumns.
- Sits between a block-level valid/ready source and sink. Round keys come from an external key-schedule store addressed by rk_idx.

---
 rtl/aes_pkg.sv | 54 +++++
 rtl/aes_mix_columns.sv | 24 ++
 rtl/aes_round_comb.sv | 35 +++
 rtl/aes_enc_round_ctrl.sv | 91 +++++++++
 tb/tb_aes_enc_round_ctrl.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: block geometry, byte/column index helpers,
// S-box table, GF(2^8) xtime and the round-controller FSM encoding.
// Byte order everywhere is column-major: byte (r + NB*c) sits at
// [127-8*(r+NB*c) -: 8], column c at [127-32*c -: 32].
package aes_pkg;

    localparam int NB = 4;
    localparam logic [7:0] XTIME_POLY = 8'h1B;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } ctrl_state_e;

    // Entry 0 is the leftmost byte of the concatenation.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? XTIME_POLY : 8'h00);
    endfunction

    // MSB position of byte (row r, column c) inside a 128-bit block.
    function automatic int byte_msb(input int r, input int c);
        return 127 - 8 * (r + NB * c);
    endfunction

    // MSB position of column c inside a 128-bit block.
    function automatic int col_msb(input int c);
        return 127 - 32 * c;
    endfunction

endpackage

// File: rtl/aes_mix_columns.sv
// MixColumns over a full 128-bit state, one independent column per
// generate lane.
//   state_in  : 128-bit state (column-major)
//   state_out : MixColumns(state_in)
module aes_mix_columns
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    output logic [127:0] state_out
);

    for (genvar c = 0; c < NB; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign {a0, a1, a2, a3} = state_in[col_msb(c) -: 32];
        // Circulant {02,03,01,01}; 03*a is xtime(a)^a.
        assign state_out[col_msb(c) -: 32] = {
            xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
        };
    end

endmodule

// File: rtl/aes_round_comb.sv
// One combinational AES encryption round:
// SubBytes -> ShiftRows -> MixColumns (skipped when last_round) -> AddRoundKey.
//   state_in   : current state
//   round_key  : key for this round
//   last_round : 1 bypasses MixColumns
//   state_out  : next state
module aes_round_comb
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         last_round,
    output logic [127:0] state_out
);

    logic [127:0] sb;
    logic [127:0] sr;
    logic [127:0] mc;

    for (genvar c = 0; c < NB; c++) begin : g_c
        for (genvar r = 0; r < NB; r++) begin : g_r
            assign sb[byte_msb(r, c) -: 8] = sbox(state_in[byte_msb(r, c) -: 8]);
            // Row r rotates left by r: out[r][c] = in[r][(c+r) mod NB].
            assign sr[byte_msb(r, c) -: 8] = sb[byte_msb(r, (c + r) % NB) -: 8];
        end
    end

    aes_mix_columns u_mix_columns (
        .state_in  (sr),
        .state_out (mc)
    );

    assign state_out = (last_round ? sr : mc) ^ round_key;

endmodule

// File: rtl/aes_enc_round_ctrl.sv
// Iterative AES encryption controller: one full round per clock on a
// 128-bit state register, initial AddRoundKey on acceptance, NR rounds
// (the last without MixColumns), then holds the result until taken.
//   clk, rst            : clock, async active-high reset
//   in_valid/in_ready   : plaintext handshake
//   plaintext           : input block
//   rk_idx/round_key    : external key store address / combinational data
//   out_valid/out_ready : ciphertext handshake
//   ciphertext          : state register
//   busy                : high in ROUND or DONE
// NR must be 10, 12 or 14 and 2**RKW must exceed NR.
module aes_enc_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR  = 10,
    parameter int RKW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [127:0]    plaintext,
    output logic [RKW-1:0]  rk_idx,
    input  logic [127:0]    round_key,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [127:0]    ciphertext,
    output logic            busy
);

    localparam logic [RKW-1:0] NR_IDX = RKW'(NR);

    ctrl_state_e    state_q, state_d;
    logic [RKW-1:0] rnd_q, rnd_d;
    logic [127:0]   state_reg_q, state_reg_d;
    logic [127:0]   round_out;
    logic           last_round;

    assign last_round = (rnd_q == NR_IDX);

    aes_round_comb u_round (
        .state_in   (state_reg_q),
        .round_key  (round_key),
        .last_round (last_round),
        .state_out  (round_out)
    );

    always_comb begin
        state_d     = state_q;
        rnd_d       = rnd_q;
        state_reg_d = state_reg_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_reg_d = plaintext ^ round_key;
                    rnd_d       = RKW'(1);
                    state_d     = ROUND;
                end
            end
            ROUND: begin
                state_reg_d = round_out;
                // Counter stops at NR so rk_idx never wraps.
                if (last_round) state_d = DONE;
                else            rnd_d   = rnd_q + RKW'(1);
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rnd_q       <= '0;
            state_reg_q <= '0;
        end else begin
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            state_reg_q <= state_reg_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q == ROUND) || (state_q == DONE);
    assign rk_idx     = (state_q == ROUND) ? rnd_q : '0;
    assign ciphertext = state_reg_q;

endmodule

// File: tb/tb_aes_enc_round_ctrl.sv
// Bench for aes_enc_round_ctrl: FIPS-197 vectors against an NR=10 and an
// NR=14 instance, each fed from a key-schedule model indexed by rk_idx.
module tb_aes_enc_round_ctrl;
    import aes_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // NR=10 instance
    logic         in_valid_a = 1'b0, out_ready_a = 1'b1;
    logic         in_ready_a, out_valid_a, busy_a;
    logic [127:0] pt_a = '0, ct_a, rkey_a;
    logic [3:0]   rk_idx_a;
    logic [127:0] rk_a [0:15];
    assign rkey_a = rk_a[rk_idx_a];

    // NR=14 instance
    logic         in_valid_b = 1'b0, out_ready_b = 1'b1;
    logic         in_ready_b, out_valid_b, busy_b;
    logic [127:0] pt_b = '0, ct_b, rkey_b;
    logic [3:0]   rk_idx_b;
    logic [127:0] rk_b [0:15];
    assign rkey_b = rk_b[rk_idx_b];

    aes_enc_round_ctrl #(.NR(10), .RKW(4)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .plaintext(pt_a), .rk_idx(rk_idx_a), .round_key(rkey_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a),
        .ciphertext(ct_a), .busy(busy_a)
    );

    aes_enc_round_ctrl #(.NR(14), .RKW(4)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .plaintext(pt_b), .rk_idx(rk_idx_b), .round_key(rkey_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
        .ciphertext(ct_b), .busy(busy_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Key-schedule model
    logic [31:0]  w [0:59];
    logic [127:0] rk_tmp [0:15];

    function automatic logic [31:0] subword(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    task automatic expand_key(input logic [255:0] key, input int nk, input int nr);
        logic [31:0]     t;
        logic [0:9][7:0] rcon;
        rcon = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subword({t[23:0], t[31:24]}) ^ {rcon[i/nk - 1], 24'h0};
            end else if (nk > 6 && i % nk == 4) begin
                t = subword(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int j = 0; j < 16; j++) begin
            if (j <= nr) rk_tmp[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
            else         rk_tmp[j] = '0;
        end
    endtask

    typedef struct {
        string        name;
        logic [255:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
        int           stall;
        bit           noise;
    } vec_t;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    vec_t vecs [4];

    // One block through the NR=10 instance, with optional output stall and
    // input noise while busy.
    task automatic run_a(input vec_t v);
        int           lat;
        bit           seq_ok;
        bit           hold_ok;
        logic [127:0] held;
        expand_key(v.key, 4, 10);
        for (int j = 0; j < 16; j++) rk_a[j] = rk_tmp[j];
        @(negedge clk);
        chk({v.name, " in_ready idle"}, in_ready_a, 1);
        chk({v.name, " rk_idx idle"}, rk_idx_a, 0);
        out_ready_a = (v.stall == 0);
        pt_a        = v.pt;
        in_valid_a  = 1'b1;
        @(negedge clk);
        in_valid_a = 1'b0;
        lat        = 0;
        seq_ok     = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            if (out_valid_a) begin
                lat = i;
                break;
            end
            if (rk_idx_a !== 4'(i) || in_ready_a !== 1'b0 || busy_a !== 1'b1) seq_ok = 1'b0;
            if (v.noise) begin
                in_valid_a = 1'($urandom_range(0, 1));
                pt_a       = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            @(negedge clk);
        end
        in_valid_a = 1'b0;
        chk({v.name, " latency"}, lat, 11);
        chk({v.name, " rk_idx sequence"}, seq_ok, 1);
        chk({v.name, " ciphertext"}, ct_a, v.ct);
        chk({v.name, " rk_idx done"}, rk_idx_a, 0);
        if (v.stall > 0) begin
            held    = ct_a;
            hold_ok = 1'b1;
            repeat (v.stall) begin
                @(negedge clk);
                if (out_valid_a !== 1'b1 || ct_a !== held || in_ready_a !== 1'b0) hold_ok = 1'b0;
            end
            chk({v.name, " stall hold"}, hold_ok, 1);
            out_ready_a = 1'b1;
        end
        @(negedge clk);
        chk({v.name, " out_valid after hs"}, out_valid_a, 0);
        chk({v.name, " in_ready after hs"}, in_ready_a, 1);
        @(negedge clk);
        chk({v.name, " no spurious accept"}, busy_a, 0);
    endtask

    initial begin
        int          lat;
        logic [3:0]  peak;

        vecs[0] = '{"appB",      {KEY_B, 128'h0}, PT_B, CT_B,  0,  1'b0};
        vecs[1] = '{"appC1",     {KEY_C, 128'h0}, PT_C, CT_C1, 0,  1'b0};
        vecs[2] = '{"appB_stall",{KEY_B, 128'h0}, PT_B, CT_B,  20, 1'b0};
        vecs[3] = '{"appB_noise",{KEY_B, 128'h0}, PT_B, CT_B,  0,  1'b1};
        for (int j = 0; j < 16; j++) begin
            rk_a[j] = '0;
            rk_b[j] = '0;
        end

        #1 rst = 1'b1;
        #1;
        chk("reset in_ready", in_ready_a, 1);
        chk("reset out_valid", out_valid_a, 0);
        chk("reset busy", busy_a, 0);
        chk("reset rk_idx", rk_idx_a, 0);
        chk("reset ciphertext", ct_a, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 4; k++) run_a(vecs[k]);

        // Async reset in the middle of round 5.
        expand_key({KEY_B, 128'h0}, 4, 10);
        for (int j = 0; j < 16; j++) rk_a[j] = rk_tmp[j];
        @(negedge clk);
        pt_a       = PT_B;
        in_valid_a = 1'b1;
        @(negedge clk);
        in_valid_a = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrun rk_idx", rk_idx_a, 5);
        #2 rst = 1'b1;
        #1;
        chk("async rst out_valid", out_valid_a, 0);
        chk("async rst in_ready", in_ready_a, 1);
        chk("async rst busy", busy_a, 0);
        @(negedge clk);
        rst = 1'b0;
        run_a(vecs[1]);

        // NR=14 instance, FIPS-197 C.3.
        expand_key({KEY_C, 128'h101112131415161718191a1b1c1d1e1f}, 8, 14);
        for (int j = 0; j < 16; j++) rk_b[j] = rk_tmp[j];
        @(negedge clk);
        pt_b       = PT_C;
        in_valid_b = 1'b1;
        @(negedge clk);
        in_valid_b = 1'b0;
        lat        = 0;
        peak       = '0;
        for (int i = 1; i <= 40; i++) begin
            if (out_valid_b) begin
                lat = i;
                break;
            end
            if (rk_idx_b > peak) peak = rk_idx_b;
            @(negedge clk);
        end
        chk("nr14 latency", lat, 15);
        chk("nr14 rk_idx peak", peak, 14);
        chk("nr14 ciphertext", ct_b, 128'h8ea2b7ca516745bfeafc49904b496089);
        @(negedge clk);
        chk("nr14 out_valid after hs", out_valid_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
        $fatal(1);
    end

endmodule
